// File: rtl/addsub_arb_pkg.sv
// rtl/addsub_arb_pkg.sv - shared widths and result layout for the add/sub round-robin arbiter
// Result record packing: sum at [3:0], carry at [4], ovf at [5], zero at [6].
package addsub_arb_pkg;

    localparam int DATA_W  = 4;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic              zero;
        logic              ovf;
        logic              carry;
        logic [DATA_W-1:0] sum;
    } result_t;

    localparam int RES_SUM_LSB   = 0;
    localparam int RES_CARRY_BIT = 4;
    localparam int RES_OVF_BIT   = 5;
    localparam int RES_ZERO_BIT  = 6;

endpackage

// File: rtl/add_sub_module.sv
// rtl/add_sub_module.sv - 4-bit adder/subtractor, m=1 computes a-b as a + ~b + 1
// Ports: a, b operands; m mode (0 add, 1 sub); s sum; c_out carry (sub: 1 = no borrow).
module add_sub_module
    import addsub_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              m,
    output logic [DATA_W-1:0] s,
    output logic              c_out
);

    logic [DATA_W-1:0] t;

    assign t = b ^ {DATA_W{m}};
    assign {c_out, s} = {1'b0, a} + {1'b0, t} + {{DATA_W{1'b0}}, m};

endmodule

// File: rtl/addsub_rr_arbiter_rr_pick.sv
// rtl/addsub_rr_arbiter_rr_pick.sv - round-robin pick: request vector + start pointer -> one-hot grant
// Ports: req request vector; ptr search start; grant one-hot; idx grant index; found any request.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    // Two copies of the request vector side by side: scanning upward from
    // ptr in the doubled vector visits ptr, ptr+1, ... with wrap for free.
    logic [2*NUM_REQ-1:0] dbl;

    assign dbl = {req, req};

    always_comb begin
        found = 1'b0;
        idx   = '0;
        grant = '0;
        for (int k = 0; k < 2 * NUM_REQ; k++) begin
            if (!found && (k >= int'(ptr)) && dbl[k]) begin
                found = 1'b1;
                idx   = ID_W'(k % NUM_REQ);
            end
        end
        if (found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// rtl/addsub_rr_arbiter.sv - round-robin share of one 4-bit add/sub datapath among NUM_REQ requesters
// Ports: clk, rst_n (async low); req_valid/req_ready/req_a/req_b/req_sub per requester;
// res_valid/res_ready handshake; res_sum, res_carry, res_ovf, res_zero, res_id result register.
module addsub_rr_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_sub,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_W-1:0]         res_sum,
    output logic                      res_carry,
    output logic                      res_ovf,
    output logic                      res_zero,
    output logic [ID_W-1:0]           res_id
);

    logic               can_issue;
    logic               found;
    logic               transfer;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    rr_ptr;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic               op_m;
    logic [DATA_W-1:0]  sum;
    logic               carry;
    logic               ovf;
    result_t            res_q;

    // rst_n gate keeps req_ready low for the whole time reset is asserted.
    assign can_issue = rst_n & (~res_valid | res_ready);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .found (found)
    );

    assign req_ready = can_issue ? grant : '0;
    assign transfer  = can_issue & found;

    // Zeros when idle so the datapath never sees unselected or X operands.
    always_comb begin
        op_a = '0;
        op_b = '0;
        op_m = 1'b0;
        if (transfer) begin
            op_a = req_a[DATA_W*int'(grant_idx) +: DATA_W];
            op_b = req_b[DATA_W*int'(grant_idx) +: DATA_W];
            op_m = req_sub[grant_idx];
        end
    end

    add_sub_module u_alu (
        .a     (op_a),
        .b     (op_b),
        .m     (op_m),
        .s     (sum),
        .c_out (carry)
    );

    // Signed overflow: operand signs (a vs effective b) agree but the result sign differs.
    assign ovf = (op_a[DATA_W-1] ^ sum[DATA_W-1]) & ~(op_a[DATA_W-1] ^ (op_b[DATA_W-1] ^ op_m));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            rr_ptr    <= '0;
        end else if (transfer) begin
            res_q.sum   <= sum;
            res_q.carry <= carry;
            res_q.ovf   <= ovf;
            res_q.zero  <= ~|sum;
            res_valid   <= 1'b1;
            res_id      <= grant_idx;
            rr_ptr      <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign res_sum   = res_q[RES_SUM_LSB +: DATA_W];
    assign res_carry = res_q[RES_CARRY_BIT];
    assign res_ovf   = res_q[RES_OVF_BIT];
    assign res_zero  = res_q[RES_ZERO_BIT];

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// tb/tb_addsub_rr_arbiter.sv - scoreboard bench for addsub_rr_arbiter with three requesters
module tb_addsub_rr_arbiter;

    localparam int N    = 3;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [4*N-1:0]  req_a;
    logic [4*N-1:0]  req_b;
    logic [N-1:0]    req_sub;
    logic            res_valid;
    logic            res_ready;
    logic [3:0]      res_sum;
    logic            res_carry;
    logic            res_ovf;
    logic            res_zero;
    logic [ID_W-1:0] res_id;

    addsub_rr_arbiter #(
        .NUM_REQ (N),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_ovf   (res_ovf),
        .res_zero  (res_zero),
        .res_id    (res_id)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int sum;
        int carry;
        int ovf;
        int zero;
        int id;
    } exp_t;

    exp_t q[$];
    int   mptr   = 0;
    bit   mvalid = 1'b0;

    // Arithmetic reference: unsigned result for sum/carry, signed range test for overflow.
    function automatic exp_t compute(input int a, input int b, input int sub, input int id);
        exp_t e;
        int raw, sa, sb, sr;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        if (sub != 0) begin
            raw = a - b + 16;
            sr  = sa - sb;
        end else begin
            raw = a + b;
            sr  = sa + sb;
        end
        e.sum   = raw % 16;
        e.carry = (raw >= 16) ? 1 : 0;
        e.ovf   = (sr < -8 || sr > 7) ? 1 : 0;
        e.zero  = (e.sum == 0) ? 1 : 0;
        e.id    = id;
        return e;
    endfunction

    // Model: decides the grant for the coming edge and pushes the expected result.
    always @(negedge clk) begin
        if (!rst_n) begin
            mptr   = 0;
            mvalid = 1'b0;
            q.delete();
        end else begin
            bit can;
            int g;
            int expv;
            can = !mvalid || res_ready;
            g   = -1;
            if (can) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
                end
            end
            expv = (g >= 0) ? (1 << g) : 0;
            check("req_ready", int'(req_ready), expv);
            check("res_valid", int'(res_valid), int'(mvalid));
            if (g >= 0) begin
                q.push_back(compute(int'(req_a[4*g +: 4]), int'(req_b[4*g +: 4]),
                                    int'(req_sub[g]), g));
                mptr   = (g + 1) % N;
                mvalid = 1'b1;
            end else if (res_ready) begin
                mvalid = 1'b0;
            end
        end
    end

    // Monitor: compares the presented result with the oldest expectation every cycle it is shown.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (q.size() == 0) begin
                check("sb_nonempty", 0, 1);
            end else begin
                check("res_sum",   int'(res_sum),   q[0].sum);
                check("res_carry", int'(res_carry), q[0].carry);
                check("res_ovf",   int'(res_ovf),   q[0].ovf);
                check("res_zero",  int'(res_zero),  q[0].zero);
                check("res_id",    int'(res_id),    q[0].id);
                if (res_ready) void'(q.pop_front());
            end
        end
    end

    // Presents one operation on requester i and returns at posedge+1 after its acceptance.
    task automatic issue(input int i, input int a, input int b, input int sub);
        bit got;
        got = 1'b0;
        req_a[4*i +: 4] = 4'(a);
        req_b[4*i +: 4] = 4'(b);
        req_sub[i]      = sub[0];
        req_valid[i]    = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        if (!got) check("issue_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    initial begin
        logic [N-1:0] prev;
        logic [N-1:0] hs;
        int           last;

        rst_n     = 1'b0;
        req_valid = 3'b011;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        res_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_res_sum",   int'(res_sum), 0);
        check("rst_res_id",    int'(res_id), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("first_grant", int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = '0;

        // Single add with signed overflow
        issue(0, 7, 1, 0);
        check("add_sum",   int'(res_sum), 8);
        check("add_carry", int'(res_carry), 0);
        check("add_ovf",   int'(res_ovf), 1);
        check("add_zero",  int'(res_zero), 0);
        check("add_id",    int'(res_id), 0);

        // Subtracts: equal operands, then a borrow
        issue(1, 5, 5, 1);
        check("sub_sum",   int'(res_sum), 0);
        check("sub_carry", int'(res_carry), 1);
        check("sub_zero",  int'(res_zero), 1);
        check("sub_ovf",   int'(res_ovf), 0);
        check("sub_id",    int'(res_id), 1);
        issue(1, 2, 3, 1);
        check("borrow_sum",   int'(res_sum), 15);
        check("borrow_carry", int'(res_carry), 0);

        // Fairness between two continuously valid requesters
        req_a     = 12'h123;
        req_b     = 12'h456;
        req_valid = 3'b011;
        prev      = '0;
        repeat (6) begin
            @(negedge clk);
            if (prev != '0) check("fair_alt", int'(req_ready != prev), 1);
            check("fair_onehot", int'(req_ready == 3'b001 || req_ready == 3'b010), 1);
            prev = req_ready;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;

        // Backpressure: result held while res_ready is low
        res_ready = 1'b0;
        issue(0, 3, 4, 0);
        req_valid = 3'b011;
        repeat (3) begin
            @(negedge clk);
            check("stall_ready", int'(req_ready), 0);
            check("stall_sum",   int'(res_sum), 7);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("drain_issue", int'(req_ready != 0), 1);
        @(posedge clk);
        #1;
        req_valid = '0;

        // All three valid: grant order wraps 2 -> 0
        req_valid = 3'b111;
        last      = -1;
        repeat (6) begin
            @(negedge clk);
            if (last >= 0) check("wrap_seq", int'(req_ready), 1 << ((last + 1) % N));
            for (int k = 0; k < N; k++) if (req_ready[k]) last = k;
        end
        @(posedge clk);
        #1;
        req_valid = '0;

        // Randomized traffic with operand hold while waiting
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || hs[i]) begin
                    req_valid[i]    = ($urandom_range(0, 2) != 0);
                    req_a[4*i +: 4] = 4'($urandom);
                    req_b[4*i +: 4] = 4'($urandom);
                    req_sub[i]      = 1'($urandom);
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end

        // Asynchronous reset between edges
        res_ready = 1'b0;
        req_valid = 3'b111;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_res_valid", int'(res_valid), 0);
        check("arst_req_ready", int'(req_ready), 0);
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ptr_zero", int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
